// File: rtl/rv_fetch_unit.sv
// Decoupled RV32I instruction-fetch stage: credit-limited in-order word requests,
// DEPTH-entry prefetch queue with a registered head, redirect flush with response dropping.
module rv_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  logic [31:0]     q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];

  cnt_t            wr_ptr, rd_ptr, outstanding, drop;
  logic [XLEN-1:0] fetch_pc, pc_tag;
  logic            run;

  cnt_t            occupancy, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_take, push, pop, head_load;
  logic [XLEN-1:0] target_pc, head_pc_nxt;
  logic [31:0]     head_data_nxt;

  always_comb begin
    occupancy   = wr_ptr - rd_ptr;
    credit_used = {1'b0, occupancy} + {1'b0, outstanding};
    target_pc   = redirect_pc & ~XLEN'(3);

    // run keeps the request port quiet for the first cycle after reset release
    imem_req_valid = run && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc;

    req_fire = imem_req_valid && imem_req_ready;
    rsp_take = imem_rsp_valid && (outstanding != '0);
    push     = rsp_take && (drop == '0) && !redirect_valid;
    pop      = inst_valid && inst_ready && !redirect_valid;

    wr_ptr_nxt = wr_ptr + cnt_t'(push);
    rd_ptr_nxt = rd_ptr + cnt_t'(pop);
    head_load  = !redirect_valid && (wr_ptr_nxt != rd_ptr_nxt);

    // When the queue drains to just the incoming word, bypass it straight to the head
    if (rd_ptr_nxt == wr_ptr) begin
      head_data_nxt = imem_rsp_data;
      head_pc_nxt   = pc_tag;
    end else begin
      head_data_nxt = q_data[rd_ptr_nxt[AW-1:0]];
      head_pc_nxt   = q_pc[rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      fetch_pc      <= RESET_PC;
      pc_tag        <= RESET_PC;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding   <= '0;
      drop          <= '0;
      inst_valid    <= 1'b0;
      inst_data     <= '0;
      inst_pc       <= '0;
      inst_pc_plus4 <= XLEN'(4);
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_take);
      if (redirect_valid) begin
        fetch_pc   <= target_pc;
        pc_tag     <= target_pc;
        rd_ptr     <= wr_ptr;
        drop       <= outstanding - cnt_t'(rsp_take);
        inst_valid <= 1'b0;
      end else begin
        if (req_fire) fetch_pc <= pc_next(fetch_pc);
        if (push) pc_tag <= pc_next(pc_tag);
        if (rsp_take && (drop != '0)) drop <= drop - cnt_t'(1);
        wr_ptr     <= wr_ptr_nxt;
        rd_ptr     <= rd_ptr_nxt;
        inst_valid <= head_load;
        if (head_load) begin
          inst_data     <= head_data_nxt;
          inst_pc       <= head_pc_nxt;
          inst_pc_plus4 <= pc_next(head_pc_nxt);
        end
      end
    end
  end

  // Queue storage carries data only; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr[AW-1:0]] <= imem_rsp_data;
      q_pc[wr_ptr[AW-1:0]]   <= pc_tag;
    end
  end

endmodule
